// File: rtl/feature_pkg.sv
// Shared defaults, element/kernel types and loader FSM encoding for the
// FeatureMem weight loader.
package feature_pkg;

    localparam int WEIGHT_W     = 2;
    localparam int KERNEL_SIZE  = 3;
    localparam int NUM_FEATURES = 10;
    localparam int KK           = KERNEL_SIZE * KERNEL_SIZE;

    typedef logic signed [WEIGHT_W-1:0] weight_t;
    typedef weight_t kernel_t [KK];

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE,
        DONE
    } loader_state_t;

endpackage

// File: rtl/feature_loader.sv
// Packs a serial valid/ready stream of signed weights into KK-element kernels
// and issues one single-cycle FeatureMem write per kernel, then pulses done.
module feature_loader #(
    parameter int  KERNEL_SIZE  = feature_pkg::KERNEL_SIZE,
    parameter int  NUM_FEATURES = feature_pkg::NUM_FEATURES,
    parameter int  WEIGHT_W     = feature_pkg::WEIGHT_W,
    localparam int KK           = KERNEL_SIZE * KERNEL_SIZE,
    localparam int AW           = $clog2(NUM_FEATURES) + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       w_valid,
    input  logic signed [WEIGHT_W-1:0] w_data,
    output logic                       w_ready,
    output logic        [AW-1:0]       address_w,
    output logic                       feature_WrEn,
    output logic signed [WEIGHT_W-1:0] feature_weights_input [KK],
    output logic                       busy,
    output logic                       done
);
    import feature_pkg::*;

    localparam int EW = $clog2(KK) + 1;

    loader_state_t               state, state_nxt;
    logic        [EW-1:0]        elem_cnt;
    logic        [AW-1:0]        kern_cnt;
    logic signed [WEIGHT_W-1:0]  wbuf [KK];
    logic                        xfer;
    logic                        last_elem;
    logic                        last_kern;

    // w_ready is exactly (state == FILL), so the handshake is decoded from
    // state here rather than from the combinational w_ready output.
    assign xfer      = (state == FILL) && w_valid;
    assign last_elem = (elem_cnt == EW'(KK - 1));
    assign last_kern = (kern_cnt == AW'(NUM_FEATURES - 1));

    assign feature_weights_input = wbuf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        w_ready      = 1'b0;
        feature_WrEn = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = FILL;
            end
            FILL: begin
                w_ready = 1'b1;
                busy    = 1'b1;
                if (w_valid && last_elem) state_nxt = WRITE;
            end
            WRITE: begin
                feature_WrEn = 1'b1;
                busy         = 1'b1;
                state_nxt    = last_kern ? DONE : FILL;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            elem_cnt  <= '0;
            kern_cnt  <= '0;
            address_w <= '0;
            for (int i = 0; i < KK; i++) wbuf[i] <= '0;
        end else begin
            if (state == IDLE && start) begin
                elem_cnt <= '0;
                kern_cnt <= '0;
            end
            if (xfer) begin
                for (int i = 0; i < KK; i++)
                    if (elem_cnt == EW'(i)) wbuf[i] <= w_data;
                elem_cnt <= last_elem ? '0 : elem_cnt + 1'b1;
                // address is latched on entry to WRITE and held afterwards
                if (last_elem) address_w <= kern_cnt;
            end
            if (state == WRITE && !last_kern) kern_cnt <= kern_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_feature_loader.sv
// Directed-sequence bench for feature_loader: a FeatureMem model captures
// writes, and expected kernel contents come straight from the source stream.
module tb_feature_loader;
    import feature_pkg::*;

    localparam int NW = 90;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                       rst = 1'b1;
    logic                       start = 1'b0;
    logic                       w_valid = 1'b0;
    logic signed [WEIGHT_W-1:0] w_data = '0;
    logic                       w_ready;
    logic [4:0]                 address_w;
    logic                       feature_WrEn;
    logic signed [WEIGHT_W-1:0] feature_weights_input [9];
    logic                       busy;
    logic                       done;

    feature_loader u_dut (
        .clk(clk), .rst(rst), .start(start), .w_valid(w_valid), .w_data(w_data),
        .w_ready(w_ready), .address_w(address_w), .feature_WrEn(feature_WrEn),
        .feature_weights_input(feature_weights_input), .busy(busy), .done(done)
    );

    logic                       start1 = 1'b0;
    logic                       w_valid1 = 1'b0;
    logic signed [WEIGHT_W-1:0] w_data1 = '0;
    logic                       w_ready1;
    logic [0:0]                 address_w1;
    logic                       feature_WrEn1;
    logic signed [WEIGHT_W-1:0] feature_weights_input1 [1];
    logic                       busy1;
    logic                       done1;

    feature_loader #(.KERNEL_SIZE(1), .NUM_FEATURES(1), .WEIGHT_W(WEIGHT_W)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .w_valid(w_valid1), .w_data(w_data1),
        .w_ready(w_ready1), .address_w(address_w1), .feature_WrEn(feature_WrEn1),
        .feature_weights_input(feature_weights_input1), .busy(busy1), .done(done1)
    );

    int n_cmp = 0;
    int n_err = 0;
    int src [NW];

    // FeatureMem model and event log
    logic signed [WEIGHT_W-1:0] mem [32][9];
    int cyc = 0;
    int wr_addr [$];
    int wr_cyc  [$];
    int done_cyc[$];
    int xfers = 0;
    int bad_rdy = 0;
    int bad_busy = 0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (feature_WrEn) begin
            wr_addr.push_back(int'(address_w));
            wr_cyc.push_back(cyc);
            for (int j = 0; j < 9; j++) mem[address_w][j] = feature_weights_input[j];
            if (w_ready) bad_rdy = bad_rdy + 1;
            if (!busy) bad_busy = bad_busy + 1;
        end
        if (done) done_cyc.push_back(cyc);
        if (w_valid && w_ready) xfers = xfers + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete(); wr_cyc.delete(); done_cyc.delete();
        xfers = 0; bad_rdy = 0; bad_busy = 0;
        for (int k = 0; k < 32; k++)
            for (int j = 0; j < 9; j++) mem[k][j] = '0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Stream src[] from index 0; stops after stop_at transfers (or all NW).
    task automatic run_load(input bit bubbles, input int pulse_at, input int stop_at);
        int  i = 0;
        int  guard = 0;
        bit  take;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (i < NW && i != stop_at && guard < 3000) begin
            w_valid = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
            w_data  = WEIGHT_W'(src[i]);
            start   = (i == pulse_at);
            @(negedge clk);
            take = w_valid && w_ready;
            tick();
            if (take) i++;
            guard++;
        end
        w_valid = 1'b0;
        start   = 1'b0;
        chk("stream_timeout", 32'(guard < 3000), 32'd1);
        if (stop_at < 0) repeat (4) tick();
    endtask

    task automatic check_load(input bit timed);
        chk("wr_count", wr_addr.size(), 10);
        chk("done_count", done_cyc.size(), 1);
        chk("xfers", xfers, NW);
        chk("ready_in_write", bad_rdy, 0);
        chk("busy_in_write", bad_busy, 0);
        for (int k = 0; k < wr_addr.size(); k++) begin
            chk("wr_addr", wr_addr[k], k);
            if (timed && k > 0) chk("wr_spacing", wr_cyc[k] - wr_cyc[k-1], 10);
        end
        if (wr_cyc.size() > 0 && done_cyc.size() > 0)
            chk("done_latency", done_cyc[0] - wr_cyc[wr_cyc.size()-1], 1);
        for (int k = 0; k < 10; k++)
            for (int j = 0; j < 9; j++)
                chk($sformatf("mem[%0d][%0d]", k, j), mem[5'(k)][j], src[9*k+j]);
        chk("idle_after", {busy, w_ready, done}, 3'b000);
    endtask

    initial begin
        logic signed [WEIGHT_W-1:0] d1;
        for (int i = 0; i < NW; i++) src[i] = (i % 4) - 2;
        clear_log();

        // 1: reset with start and w_valid asserted
        start = 1'b1; w_valid = 1'b1; w_data = WEIGHT_W'(src[0]); w_valid1 = 1'b1;
        repeat (3) tick();
        chk("rst_wr_ready", w_ready, 0);
        chk("rst_wren", feature_WrEn, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", address_w, 0);
        chk("rst_buf0", feature_weights_input[0], 0);
        chk("rst_buf8", feature_weights_input[8], 0);
        chk("rst_dut1_ready", {w_ready1, busy1, feature_WrEn1}, 0);
        start = 1'b0; w_valid1 = 1'b0;
        rst = 1'b0;
        repeat (3) tick();
        chk("idle_no_ready", w_ready, 0);
        chk("idle_no_busy", busy, 0);
        chk("idle_no_xfer", xfers, 0);
        chk("idle_no_write", wr_addr.size(), 0);
        w_valid = 1'b0;
        clear_log();

        // 2: full load, no bubbles
        run_load(1'b0, -1, -1);
        check_load(1'b1);
        clear_log();

        // 3: same data with random bubbles
        run_load(1'b1, -1, -1);
        check_load(1'b0);
        clear_log();

        // 4: w_valid in IDLE is not consumed; start during FILL is ignored
        w_valid = 1'b1; w_data = WEIGHT_W'(src[0]);
        repeat (4) tick();
        chk("idle_valid_ready", w_ready, 0);
        chk("idle_valid_xfer", xfers, 0);
        run_load(1'b1, 22, -1);
        check_load(1'b0);
        clear_log();

        // 5: reset at kernel 3 element 4, then a fresh random load
        run_load(1'b0, -1, 31);
        chk("pre_rst_xfers", xfers, 31);
        chk("pre_rst_writes", wr_addr.size(), 3);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", w_ready, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_addr", address_w, 0);
        chk("mid_rst_wren_done", {feature_WrEn, done}, 0);
        chk("mid_rst_buf0", feature_weights_input[0], 0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        clear_log();
        for (int i = 0; i < NW; i++) src[i] = int'($urandom_range(0, 3)) - 2;
        run_load(1'b1, -1, -1);
        check_load(1'b0);
        clear_log();

        // 6: KERNEL_SIZE=1, NUM_FEATURES=1
        d1 = WEIGHT_W'($urandom_range(0, 3));
        start1 = 1'b1;
        tick();
        start1 = 1'b0; w_valid1 = 1'b1; w_data1 = d1;
        chk("k1_fill_ready", {w_ready1, busy1}, 2'b11);
        tick();
        w_valid1 = 1'b0;
        chk("k1_wren", feature_WrEn1, 1);
        chk("k1_addr", address_w1, 0);
        chk("k1_data", feature_weights_input1[0], d1);
        chk("k1_write_ready", w_ready1, 0);
        tick();
        chk("k1_done", {done1, busy1, feature_WrEn1}, 3'b100);
        tick();
        chk("k1_idle", {done1, busy1, w_ready1}, 3'b000);
        chk("k1_addr_hold", address_w1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
